// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared state encoding and default sizing for the PUF race sequencer
package puf_pkg;

  localparam int          PUF_CW        = 64;
  localparam int          PUF_RESP_BITS = 32;
  localparam logic [63:0] PUF_LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LAUNCH,
    WAIT,
    SAMPLE,
    NEXT,
    OUT
  } state_t;

endpackage

// File: rtl/puf_lfsr.sv
// rtl/puf_lfsr.sv - challenge register: seed load (zero seed forced to 1) and Fibonacci LFSR step
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int            CW   = PUF_CW,
  parameter logic [CW-1:0] TAPS = PUF_LFSR_TAPS[CW-1:0]
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [CW-1:0] seed,
  output logic [CW-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= (seed == '0) ? CW'(1) : seed;
    end else if (step) begin
      value <= {value[CW-2:0], ^(value & TAPS)};
    end
  end

endmodule

// File: rtl/puf_race_sequencer.sv
// rtl/puf_race_sequencer.sv - steps challenges through the delay chains, races the arbiter per bit
// and assembles the response word with timeout detection and a valid/ready result handshake.
module puf_race_sequencer
  import puf_pkg::*;
#(
  parameter int            CW         = PUF_CW,
  parameter int            RESP_BITS  = PUF_RESP_BITS,
  parameter logic [CW-1:0] LFSR_TAPS  = PUF_LFSR_TAPS[CW-1:0],
  parameter int            CLR_CYCLES = 4,
  parameter int            TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CW-1:0]        seed,
  output logic                 busy,
  output logic [CW-1:0]        chal,
  output logic                 launch,
  output logic                 arb_reset,
  input  logic                 arb_done,
  input  logic                 arb_out,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 timeout_err
);

  localparam int               CNT_W        = $clog2(TIMEOUT + 1);
  localparam int               BIT_W        = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_CLR_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(RESP_BITS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             race_bit;
  logic             done_meta;
  logic             done_s;
  logic             out_meta;
  logic             out_s;
  logic             chal_load;
  logic             chal_step;

  // Arbiter outputs come from the asynchronous race domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_meta <= 1'b0;
      done_s    <= 1'b0;
      out_meta  <= 1'b0;
      out_s     <= 1'b0;
    end else begin
      done_meta <= arb_done;
      done_s    <= done_meta;
      out_meta  <= arb_out;
      out_s     <= out_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    chal_load = 1'b0;
    chal_step = 1'b0;
    case (state)
      IDLE: begin
        if (start && !resp_valid) begin
          chal_load = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt == CNT_CLR_LAST) state_nxt = LAUNCH;
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        // A done arriving on the timeout cycle still wins.
        if (done_s)                   state_nxt = SAMPLE;
        else if (cnt == CNT_TIMEOUT)  state_nxt = NEXT;
      end
      SAMPLE: state_nxt = NEXT;
      NEXT: begin
        chal_step = 1'b1;
        state_nxt = (bit_cnt == BIT_LAST) ? OUT : CLEAR;
      end
      OUT: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign resp_valid = (state == OUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      bit_cnt     <= '0;
      race_bit    <= 1'b0;
      resp        <= '0;
      timeout_err <= 1'b0;
      launch      <= 1'b0;
      arb_reset   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          arb_reset <= 1'b1;
          launch    <= 1'b0;
          if (chal_load) begin
            bit_cnt     <= '0;
            resp        <= '0;
            timeout_err <= 1'b0;
            cnt         <= '0;
          end
        end
        CLEAR: begin
          cnt <= (cnt == CNT_CLR_LAST) ? '0 : cnt + 1'b1;
        end
        LAUNCH: begin
          arb_reset <= 1'b0;
          launch    <= 1'b1;
          cnt       <= '0;
        end
        WAIT: begin
          if (!done_s) begin
            if (cnt == CNT_TIMEOUT) begin
              race_bit    <= 1'b0;
              timeout_err <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SAMPLE: race_bit <= out_s;
        NEXT: begin
          resp[bit_cnt] <= race_bit;
          launch        <= 1'b0;
          arb_reset     <= 1'b1;
          cnt           <= '0;
          if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  puf_lfsr #(
    .CW   (CW),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (chal_load),
    .step  (chal_step),
    .seed  (seed),
    .value (chal)
  );

endmodule

// File: tb/tb_puf_race_sequencer.sv
// tb/tb_puf_race_sequencer.sv - directed table-driven bench for puf_race_sequencer with a race arbiter model
module tb_puf_race_sequencer;

  localparam int CW  = 64;
  localparam int RB  = 8;
  localparam int TO  = 1023;
  localparam int CLR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] seed;
  logic          busy;
  logic [CW-1:0] chal;
  logic          launch;
  logic          arb_reset;
  logic          arb_done;
  logic          arb_out;
  logic [RB-1:0] resp;
  logic          resp_valid;
  logic          resp_ready;
  logic          timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  // arbiter model configuration (written only by the stimulus process)
  logic          model_rst;
  logic [RB-1:0] out_pat;
  int            to_race;
  int            tie_race;
  int            stale_cycles;

  // arbiter model state (written only by the model process)
  int   race_idx;
  int   dly;
  int   rst_cnt;
  int   thr;
  logic prev_launch;

  typedef struct {
    logic [CW-1:0] seed;
    logic [RB-1:0] pat;
    int            to_race;
    int            tie_race;
    int            stale;
    int            hold;
    logic [RB-1:0] exp_resp;
    logic          exp_terr;
    logic [CW-1:0] exp_c0;
    logic [CW-1:0] exp_c1;
    int            spec_race;
    int            exp_spec_hi;
  } vec_t;

  vec_t vecs[4];

  puf_race_sequencer #(
    .CW         (CW),
    .RESP_BITS  (RB),
    .CLR_CYCLES (CLR),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .seed        (seed),
    .busy        (busy),
    .chal        (chal),
    .launch      (launch),
    .arb_reset   (arb_reset),
    .arb_done    (arb_done),
    .arb_out     (arb_out),
    .resp        (resp),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Race arbiter: decision after 3 cycles of launch (or TO-1 on the tie race), done clears
  // stale_cycles+1 cycles after arb_reset rises, never completes on to_race.
  always @(negedge clk) begin
    if (model_rst) begin
      race_idx    = 0;
      dly         = 0;
      rst_cnt     = 0;
      prev_launch = 1'b0;
      arb_done    = 1'b0;
      arb_out     = 1'b0;
    end else begin
      if (prev_launch && !launch) race_idx = race_idx + 1;
      prev_launch = launch;
      thr = (race_idx == tie_race) ? TO - 1 : 3;
      if (arb_reset) begin
        rst_cnt = rst_cnt + 1;
        dly     = 0;
        if (rst_cnt > stale_cycles) arb_done = 1'b0;
      end else begin
        rst_cnt = 0;
        if (launch && !arb_done && race_idx != to_race && race_idx < RB) begin
          dly = dly + 1;
          if (dly == thr - 1) arb_out = out_pat[race_idx];
          if (dly == thr) arb_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic arm_model(input logic [RB-1:0] pat, input int tr, input int tie, input int st);
    out_pat      = pat;
    to_race      = tr;
    tie_race     = tie;
    stale_cycles = st;
    model_rst    = 1'b1;
    @(negedge clk);
    model_rst    = 1'b0;
  endtask

  task automatic run_eval(input int idx);
    vec_t v;
    int hi[RB];
    int hcnt;
    int r;
    int lo1;
    int cyc;
    logic [CW-1:0] c1;
    v = vecs[idx];
    foreach (hi[i]) hi[i] = 0;
    hcnt = 0;
    r    = 0;
    lo1  = 0;
    cyc  = 0;
    c1   = '0;
    arm_model(v.pat, v.to_race, v.tie_race, v.stale);
    seed  = v.seed;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d busy_in_clear", idx), 64'(busy), 64'd1);
    chk($sformatf("v%0d chal_race0", idx), chal, v.exp_c0);
    chk($sformatf("v%0d arb_reset_clear", idx), 64'(arb_reset), 64'd1);
    while (!resp_valid && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (launch) begin
        hcnt++;
      end else begin
        if (hcnt > 0) begin
          if (r < RB) hi[r] = hcnt;
          if (r == 0) c1 = chal;
          hcnt = 0;
          r++;
        end
        if (r == 1) lo1++;
      end
    end
    chk($sformatf("v%0d eval_completes", idx), 64'(resp_valid), 64'd1);
    chk($sformatf("v%0d resp", idx), 64'(resp), 64'(v.exp_resp));
    chk($sformatf("v%0d timeout_err", idx), 64'(timeout_err), 64'(v.exp_terr));
    chk($sformatf("v%0d chal_race1", idx), c1, v.exp_c1);
    chk($sformatf("v%0d launch_hi_race0", idx), 64'(hi[0]), 64'd7);
    chk($sformatf("v%0d launch_hi_race1", idx), 64'(hi[1]), 64'd7);
    chk($sformatf("v%0d launch_lo_clear", idx), 64'(lo1), 64'(CLR + 1));
    if (v.spec_race >= 0)
      chk($sformatf("v%0d launch_hi_race%0d", idx, v.spec_race), 64'(hi[v.spec_race]),
          64'(v.exp_spec_hi));
    for (int i = 0; i < v.hold; i++) begin
      start = ((i % 5) == 0);
      @(negedge clk);
      chk($sformatf("v%0d hold_valid_%0d", idx, i), 64'(resp_valid), 64'd1);
      chk($sformatf("v%0d hold_resp_%0d", idx, i), 64'(resp), 64'(v.exp_resp));
    end
    start      = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk($sformatf("v%0d valid_after_ready", idx), 64'(resp_valid), 64'd0);
    chk($sformatf("v%0d busy_after_ready", idx), 64'(busy), 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d stays_idle", idx), 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{64'h0, 8'h25, -1, -1, 0, 0, 8'h25, 1'b0,
                64'h1, 64'h2, -1, 0};
    vecs[1] = '{64'h8000_0000_0000_0001, 8'hFF, 4, -1, 0, 20, 8'hEF, 1'b1,
                64'h8000_0000_0000_0001, 64'h3, 4, TO + 2};
    vecs[2] = '{64'hF000_0000_0000_0000, 8'hA5, -1, -1, 3, 0, 8'hA5, 1'b0,
                64'hF000_0000_0000_0000, 64'hE000_0000_0000_0001, -1, 0};
    vecs[3] = '{64'h0123_4567_89AB_CDEF, 8'h4C, -1, 6, 0, 0, 8'h4C, 1'b0,
                64'h0123_4567_89AB_CDEF, 64'h0246_8ACF_1357_9BDE, 6, TO + 3};

    reset        = 1'b1;
    start        = 1'b0;
    seed         = '0;
    resp_ready   = 1'b0;
    model_rst    = 1'b1;
    out_pat      = '0;
    to_race      = -1;
    tie_race     = -1;
    stale_cycles = 0;
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst chal", chal, 64'd0);
    chk("rst launch", 64'(launch), 64'd0);
    chk("rst arb_reset", 64'(arb_reset), 64'd1);
    chk("rst resp", 64'(resp), 64'd0);
    chk("rst resp_valid", 64'(resp_valid), 64'd0);
    chk("rst timeout_err", 64'(timeout_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // reset while waiting on race 3 aborts the evaluation
    arm_model(8'hFF, -1, -1, 0);
    seed  = 64'h5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!(race_idx == 3 && launch) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort reached race3 wait", 64'(launch), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort arb_reset", 64'(arb_reset), 64'd1);
    chk("abort launch", 64'(launch), 64'd0);
    chk("abort resp_valid", 64'(resp_valid), 64'd0);
    chk("abort resp", 64'(resp), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // resp_ready while idle must not matter
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle ready busy", 64'(busy), 64'd0);

    for (int i = 0; i < 4; i++) run_eval(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
